sha256: RTL and testbench
=========================

# sha256

Single-block SHA-256 compression engine. Takes one already-padded 512-bit message block and computes the FIPS 180-4 digest from the standard initial hash value. It runs one round per clock, raises `ready` when the digest is valid, and holds the result until the next reset. It sits behind a board-level controller that loads `data`, pulses reset to start a computation, and compares `hash` against an expected value.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset. Releasing it (0→1) starts a new computation.
- `data`  in  512, declared `[0:511]`  padded message block. `data[0:31]` is W0 and `data[480:511]` is W15. Bit 0 is the MSB of W0.
- `ready`  out  1  digest valid. Sticky until the next reset.
- `hash`  out  256  digest. `hash[255:224]`=H0 … `hash[31:0]`=H7.

## Operation
- No padding is performed. The caller supplies a fully padded block.
- FSM states: IDLE (in reset) → LOAD → ROUND (64 cycles) → FINAL → DONE.
- Reset asserted (reset=0):
  - FSM goes to IDLE.
  - `ready`=0, `hash`=0.
  - Round counter = 0.
  - Working registers a..h are cleared.
- LOAD:
  - Capture `data` into a 16-word schedule window.
  - Set a..h to the IV: 6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19.
- ROUND t=0..63, one per clock:
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[t].
  - T2 = Σ0(a) + Maj(a,b,c).
  - Shift the registers. Then a = T1+T2 and e = d+T1.
  - For t≥16, W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16]. The window slides by one word each round.
  - All additions are modulo 2^32 and carries are discarded.
- FINAL: Hi = IVi + working variable i (mod 2^32). The result is registered into `hash`.
- DONE:
  - `ready`=1 and `hash` holds the digest.
  - `data` changes are ignored.
  - The FSM stays here until reset is asserted.
- `data` is sampled only in LOAD. Changes during ROUND do not affect the result.

## Timing
- Reset release takes effect at the first rising edge where reset=1. That edge performs LOAD.
- Edge 1: LOAD. Edges 2–65: rounds 0–63. Edge 66: FINAL, which also sets `ready`=1 and `hash` valid.
- Latency is 66 clocks from the first edge after reset release.
- If reset is asserted mid-computation, the core aborts immediately and asynchronously. All outputs return to their reset values. The next release restarts from LOAD with the current `data`.
- Reset asserted while in DONE clears `ready` and `hash` asynchronously.
- `ready` never pulses low between FINAL and the next reset.

## Configuration
- `SHA256_HASH_MASK_EN` defined:
  - `hash` is forced to 0 whenever `ready`=0.
  - The digest appears only together with `ready`.
- Not defined:
  - `hash` drives the output register directly.
  - That register is 0 from reset until FINAL, so the value is identical in practice.
  - The output AND-gating is omitted to save logic.

## Structure
- Package `sha256_pkg` holds:
  - the 64-entry K constant array and the 8-word IV;
  - the FSM state enum;
  - functions Ch, Maj, Σ0, Σ1, σ0, σ1 (32-bit rotates and shifts).
- Sub-module `sha256_round`: combinational single round.
  - Inputs: a..h, K[t], W[t].
  - Outputs: the next a..h.
  - It is instantiated once in the core.
- The message schedule window and the round counter (6-bit) live in the top module.

## Test plan
- Vector A:
  - Stimulus: `data` = 03633cbe3ec02b9401c5effa144c5b4d22f87940259634858fc7e59b1c099378528000…000108 (512 bits, zero fill), then release reset.
  - Response: `hash` = 92d0bf55a6ecef50e36e9a605e4216c20f38c70635c2fb627de9d404689956b2 when `ready` rises.
- Vector B:
  - Stimulus: same as A but byte 32 = 53, i.e. …99378538000…0108.
  - Response: `hash` = 03497feb0e4fafd392f8fe9ef6eed2c4ea1d942051dda7aaf211c0743df1a7a5.
- "abc":
  - Stimulus: `data` = 61626380, zeros, last word 00000018.
  - Response: `hash` = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- Empty message:
  - Stimulus: `data` = 80000000 followed by zeros.
  - Response: `hash` = e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- Latency and stickiness:
  - Stimulus: count edges from reset release; after `ready` rises, hold 100 more cycles and toggle `data`.
  - Response: `ready`=0 for edges 1–65 and 1 at edge 66. `ready` and `hash` stay constant afterwards.
- Mid-run reset:
  - Stimulus: assert reset at round 30 with vector A loaded; switch `data` to vector B; release reset.
  - Response: `ready` and `hash` go to 0 immediately. The restart finishes 66 edges after release with vector B's digest.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared constants, types and bit-level helpers for the single-block SHA-256 core.
package sha256_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BLOCK_W = 512;
    localparam int unsigned HASH_W  = 256;
    localparam int unsigned ROUNDS  = 64;
    localparam int unsigned CNT_W   = 6;
    localparam int unsigned WIN_N   = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        word_t a, b, c, d, e, f, g, h;
    } work_t;

    typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} state_t;

    localparam work_t IV = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam word_t K [0:ROUNDS-1] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_if.sv
// Block/digest bundle between the board controller (master) and the SHA-256 core (slave).
interface sha256_if;
    import sha256_pkg::*;

    logic [0:BLOCK_W-1] data;
    logic               ready;
    logic [HASH_W-1:0]  hash;

    modport master (output data, input ready, input hash);
    modport slave  (input data, output ready, output hash);
endinterface

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round: working variables in, next working variables out.
module sha256_round
    import sha256_pkg::*;
(
    input  work_t cur,
    input  word_t k,
    input  word_t w,
    output work_t nxt_c
);

    word_t t1;
    word_t t2;

    always_comb begin
        t1    = cur.h + big_sigma1(cur.e) + ch(cur.e, cur.f, cur.g) + k + w;
        t2    = big_sigma0(cur.a) + maj(cur.a, cur.b, cur.c);
        nxt_c = '{t1 + t2, cur.a, cur.b, cur.c, cur.d + t1, cur.e, cur.f, cur.g};
    end

endmodule

// File: rtl/sha256.sv
// Single-block SHA-256 engine: reset release starts LOAD, 64 rounds, FINAL, then a sticky DONE.
// Define SHA256_HASH_MASK_EN to gate the hash output with ready.
module sha256
    import sha256_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    sha256_if.slave  bus
);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    work_t             work;
    word_t             win [WIN_N];
    logic              ready_q;
    logic [HASH_W-1:0] hash_q;

    work_t work_nxt_c;
    word_t win_new_c;

    sha256_round u_round (
        .cur   (work),
        .k     (K[cnt]),
        .w     (win[0]),
        .nxt_c (work_nxt_c)
    );

    // Next schedule word W[t+16] from the current window W[t..t+15].
    assign win_new_c = small_sigma1(win[14]) + win[9] + small_sigma0(win[1]) + win[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            work    <= '0;
            ready_q <= 1'b0;
            hash_q  <= '0;
            for (int i = 0; i < WIN_N; i++) win[i] <= '0;
        end else begin
            case (state)
                // The first edge after reset release performs the load.
                IDLE, LOAD: begin
                    for (int i = 0; i < WIN_N; i++) win[i] <= bus.data[WORD_W*i +: WORD_W];
                    work  <= IV;
                    cnt   <= '0;
                    state <= ROUND;
                end
                ROUND: begin
                    work <= work_nxt_c;
                    for (int i = 0; i < WIN_N - 1; i++) win[i] <= win[i+1];
                    win[WIN_N-1] <= win_new_c;
                    cnt          <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(ROUNDS - 1)) state <= FINAL;
                end
                FINAL: begin
                    hash_q  <= {IV.a + work.a, IV.b + work.b, IV.c + work.c, IV.d + work.d,
                                IV.e + work.e, IV.f + work.f, IV.g + work.g, IV.h + work.h};
                    ready_q <= 1'b1;
                    state   <= DONE;
                end
                DONE:    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready = ready_q;
`ifdef SHA256_HASH_MASK_EN
    assign bus.hash = hash_q & {HASH_W{ready_q}};
`else
    assign bus.hash = hash_q;
`endif

endmodule

// File: tb/tb_sha256.sv
// Directed and randomized bench for sha256 with an array-based FIPS 180-4 reference model.
module tb_sha256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sha256_if bus ();
    sha256 dut (.clk(clk), .reset(rst), .bus(bus));

    localparam logic [31:0] RK [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] RIV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [0:511] BLK_A = {32'h03633cbe, 32'h3ec02b94, 32'h01c5effa, 32'h144c5b4d,
                                      32'h22f87940, 32'h25963485, 32'h8fc7e59b, 32'h1c099378,
                                      32'h52800000, 192'h0, 32'h00000108};
    localparam logic [0:511] BLK_B = {32'h03633cbe, 32'h3ec02b94, 32'h01c5effa, 32'h144c5b4d,
                                      32'h22f87940, 32'h25963485, 32'h8fc7e59b, 32'h1c099378,
                                      32'h53800000, 192'h0, 32'h00000108};
    localparam logic [0:511] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [0:511] BLK_EMPTY = {32'h80000000, 480'h0};

    localparam logic [255:0] EXP_A     = 256'h92d0bf55a6ecef50e36e9a605e4216c20f38c70635c2fb627de9d404689956b2;
    localparam logic [255:0] EXP_B     = 256'h03497feb0e4fafd392f8fe9ef6eed2c4ea1d942051dda7aaf211c0743df1a7a5;
    localparam logic [255:0] EXP_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EXP_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Whole-message reference: expand all 64 schedule words, then iterate the 8-word state.
    function automatic logic [255:0] ref_hash(input logic [0:511] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] s0, s1, t1, t2;
        logic [255:0] res;
        for (int t = 0; t < 16; t++) w[t] = blk[32*t +: 32];
        for (int t = 16; t < 64; t++) begin
            s0   = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
            s1   = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
        for (int i = 0; i < 8; i++) v[i] = RIV[i];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
                 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + RK[t] + w[t];
            t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
                 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) res[255-32*i -: 32] = RIV[i] + v[i];
        return res;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reset was just released on a falling edge; count rising edges until ready.
    task automatic wait_done(input logic [255:0] exp, input string tag);
        int n = 0;
        while (n < 200) begin
            @(posedge clk); #1;
            n++;
            if (bus.ready === 1'b1) break;
        end
        check({tag, "_latency"}, 256'(n), 256'd66);
        check({tag, "_hash"}, bus.hash, exp);
    endtask

    task automatic run(input logic [0:511] blk, input logic [255:0] exp, input string tag);
        @(negedge clk);
        rst      = 1'b0;
        bus.data = blk;
        @(negedge clk);
        rst = 1'b1;
        wait_done(exp, tag);
    endtask

    initial begin
        logic [0:511] blk;
        bus.data = '0;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 256'(bus.ready), 256'd0);
        check("reset_hash", bus.hash, 256'd0);

        run(BLK_A, EXP_A, "vec_a");

        // Sticky DONE: data changes must not disturb ready or hash.
        for (int i = 0; i < 100; i++) begin
            for (int j = 0; j < 16; j++) bus.data[32*j +: 32] = $urandom();
            @(posedge clk); #1;
            check("sticky_ready", 256'(bus.ready), 256'd1);
            check("sticky_hash", bus.hash, EXP_A);
        end

        @(negedge clk);
        rst = 1'b0;
        #1;
        check("done_reset_ready", 256'(bus.ready), 256'd0);
        check("done_reset_hash", bus.hash, 256'd0);

        run(BLK_B, EXP_B, "vec_b");
        run(BLK_ABC, EXP_ABC, "abc");
        run(BLK_EMPTY, EXP_EMPTY, "empty");

        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 16; j++) blk[32*j +: 32] = $urandom();
            run(blk, ref_hash(blk), $sformatf("rand%0d", r));
        end

        // Abort at round 30 (edge 32) and restart with a different block.
        @(negedge clk);
        rst      = 1'b0;
        bus.data = BLK_A;
        @(negedge clk);
        rst = 1'b1;
        repeat (32) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrun_ready", 256'(bus.ready), 256'd0);
        check("midrun_hash", bus.hash, 256'd0);
        bus.data = BLK_B;
        @(negedge clk);
        rst = 1'b1;
        wait_done(ref_hash(BLK_B), "midrun_restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
